// File: rtl/rob.sv
// Circular reorder buffer: allocates at the tail, retires in order from the head,
// completes entries by CDB tag or execute-stage strobe, and squashes on a mispredicted branch commit.
module rob #(
    parameter int unsigned ROB_SIZE  = 32,
    parameter int unsigned ROB_WIDTH = 5,
    parameter int unsigned ARF_WIDTH = 5,
    parameter int unsigned PRF_WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 id_rs_valid_inst_in,
    input  logic [ARF_WIDTH-1:0] id_rs_ARF_num_in,
    input  logic [PRF_WIDTH-1:0] id_rs_PRF_num_in,
    input  logic                 id_rs_is_branch_inst_in,
    input  logic                 id_rs_is_store_inst_in,
    input  logic [63:0]          ex_NPC_in,
    input  logic                 ex_branch_mispredict_in,
    input  logic                 ex_branch_inst_in,
    input  logic                 ex_store_inst_in,
    input  logic [ROB_WIDTH-1:0] ex_ROB_num_in,
    input  logic [PRF_WIDTH-1:0] CDB_tag_in,
    output logic [ARF_WIDTH-1:0] ROB_ARF_num_out,
    output logic [PRF_WIDTH-1:0] ROB_PRF_num_out,
    output logic [63:0]          ROB_NPC_out,
    output logic                 ROB_branch_mispredict_out,
    output logic                 ROB_is_store_inst_out,
    output logic                 ROB_is_branch_inst_out,
    output logic                 ROB_commit_out,
    output logic                 ROB_dispatch_disable,
    output logic [ROB_WIDTH-1:0] ROB_head,
    output logic [ROB_WIDTH-1:0] ROB_tail
);

    localparam int unsigned NPC_WIDTH = 64;

    typedef struct packed {
        logic                 valid;
        logic                 complete;
        logic [ARF_WIDTH-1:0] arf;
        logic [PRF_WIDTH-1:0] prf;
        logic [NPC_WIDTH-1:0] npc;
        logic                 mispredict;
        logic                 is_store;
        logic                 is_branch;
    } entry_t;

    entry_t               entry_q [ROB_SIZE];
    entry_t               entry_d [ROB_SIZE];
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;

    logic commit_c, full_c, dispatch_c, squash_c;
    entry_t head_entry_c, ex_entry_c;

    assign head_entry_c = entry_q[head_q];
    assign ex_entry_c   = entry_q[ex_ROB_num_in];

    // Head entry is exposed unconditionally, stale contents included.
    assign ROB_ARF_num_out           = head_entry_c.arf;
    assign ROB_PRF_num_out           = head_entry_c.prf;
    assign ROB_NPC_out               = head_entry_c.npc;
    assign ROB_branch_mispredict_out = head_entry_c.mispredict;
    assign ROB_is_store_inst_out     = head_entry_c.is_store;
    assign ROB_is_branch_inst_out    = head_entry_c.is_branch;
    assign ROB_head                  = head_q;
    assign ROB_tail                  = tail_q;

    assign commit_c             = head_entry_c.valid & head_entry_c.complete;
    assign full_c               = entry_q[tail_q].valid;
    assign ROB_dispatch_disable = full_c & ~commit_c;
    assign ROB_commit_out       = commit_c;
    assign dispatch_c           = id_rs_valid_inst_in & ~ROB_dispatch_disable;
    assign squash_c             = commit_c & head_entry_c.is_branch & head_entry_c.mispredict;

    // Next-state: completions, then commit, then dispatch (dispatch wins its slot), squash last.
    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;

        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if (entry_q[i].valid && !entry_q[i].is_store && !entry_q[i].is_branch
                && (entry_q[i].prf == CDB_tag_in)) begin
                entry_d[i].complete = 1'b1;
            end
        end

        if (ex_store_inst_in && ex_entry_c.valid && ex_entry_c.is_store) begin
            entry_d[ex_ROB_num_in].complete = 1'b1;
        end

        if (ex_branch_inst_in && ex_entry_c.valid && ex_entry_c.is_branch) begin
            entry_d[ex_ROB_num_in].complete   = 1'b1;
            entry_d[ex_ROB_num_in].npc        = ex_NPC_in;
            entry_d[ex_ROB_num_in].mispredict = ex_branch_mispredict_in;
        end

        if (commit_c) begin
            entry_d[head_q].valid = 1'b0;
            head_d                = head_q + ROB_WIDTH'(1);
        end

        if (dispatch_c) begin
            entry_d[tail_q].valid      = 1'b1;
            entry_d[tail_q].complete   = 1'b0;
            entry_d[tail_q].arf        = id_rs_ARF_num_in;
            entry_d[tail_q].prf        = id_rs_PRF_num_in;
            entry_d[tail_q].npc        = '0;
            entry_d[tail_q].mispredict = 1'b0;
            entry_d[tail_q].is_store   = id_rs_is_store_inst_in;
            entry_d[tail_q].is_branch  = id_rs_is_branch_inst_in;
            tail_d                     = tail_q + ROB_WIDTH'(1);
        end

        if (squash_c) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entry_d[i] = '0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed fill/drain/squash scenarios plus a randomized run
// checked against an occupancy-count model of the buffer.
module tb_rob;

    localparam int unsigned N = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_arf;
    logic [5:0]  id_prf;
    logic        id_br;
    logic        id_st;
    logic [63:0] ex_npc;
    logic        ex_misp;
    logic        ex_br;
    logic        ex_st;
    logic [4:0]  ex_num;
    logic [5:0]  cdb;

    logic [4:0]  o_arf;
    logic [5:0]  o_prf;
    logic [63:0] o_npc;
    logic        o_misp, o_st, o_br, o_commit, o_dis;
    logic [4:0]  o_head, o_tail;

    int total = 0;
    int bad   = 0;

    rob dut (
        .clock                    (clock),
        .reset                    (reset),
        .id_rs_valid_inst_in      (id_valid),
        .id_rs_ARF_num_in         (id_arf),
        .id_rs_PRF_num_in         (id_prf),
        .id_rs_is_branch_inst_in  (id_br),
        .id_rs_is_store_inst_in   (id_st),
        .ex_NPC_in                (ex_npc),
        .ex_branch_mispredict_in  (ex_misp),
        .ex_branch_inst_in        (ex_br),
        .ex_store_inst_in         (ex_st),
        .ex_ROB_num_in            (ex_num),
        .CDB_tag_in               (cdb),
        .ROB_ARF_num_out          (o_arf),
        .ROB_PRF_num_out          (o_prf),
        .ROB_NPC_out              (o_npc),
        .ROB_branch_mispredict_out(o_misp),
        .ROB_is_store_inst_out    (o_st),
        .ROB_is_branch_inst_out   (o_br),
        .ROB_commit_out           (o_commit),
        .ROB_dispatch_disable     (o_dis),
        .ROB_head                 (o_head),
        .ROB_tail                 (o_tail)
    );

    always #5 clock = ~clock;

    // Reference model: slot contents plus (head, count); occupancy is derived, not stored.
    logic [4:0]  m_arf  [N];
    logic [5:0]  m_prf  [N];
    logic [63:0] m_npc  [N];
    logic        m_misp [N];
    logic        m_st   [N];
    logic        m_br   [N];
    logic        m_cmp  [N];
    int unsigned m_head;
    int unsigned m_cnt;

    function automatic bit in_rob(int unsigned i);
        return ((i + N - m_head) % N) < m_cnt;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_arf[i] = '0; m_prf[i] = '0; m_npc[i] = '0;
            m_misp[i] = 1'b0; m_st[i] = 1'b0; m_br[i] = 1'b0; m_cmp[i] = 1'b0;
        end
        m_head = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit          commit, stall, dispatch;
        int unsigned tail;
        int unsigned x;
        commit   = (m_cnt != 0) && m_cmp[m_head];
        stall    = (m_cnt == N) && !commit;
        dispatch = id_valid && !stall;
        tail     = (m_head + m_cnt) % N;
        x        = int'(ex_num);
        if (commit && m_br[m_head] && m_misp[m_head]) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++)
            if (in_rob(i) && !m_st[i] && !m_br[i] && m_prf[i] == cdb) m_cmp[i] = 1'b1;
        if (ex_st && in_rob(x) && m_st[x]) m_cmp[x] = 1'b1;
        if (ex_br && in_rob(x) && m_br[x]) begin
            m_cmp[x] = 1'b1; m_npc[x] = ex_npc; m_misp[x] = ex_misp;
        end
        if (commit) begin
            m_head = (m_head + 1) % N;
            m_cnt  = m_cnt - 1;
        end
        if (dispatch) begin
            m_arf[tail] = id_arf; m_prf[tail] = id_prf; m_npc[tail] = '0;
            m_misp[tail] = 1'b0; m_st[tail] = id_st; m_br[tail] = id_br; m_cmp[tail] = 1'b0;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_arf = '0; id_prf = '0; id_br = 0; id_st = 0;
        ex_npc = '0; ex_misp = 0; ex_br = 0; ex_st = 0; ex_num = '0; cdb = '0;
    endtask

    // Advance one clock; inputs set before the call are sampled at the posedge.
    task automatic tick();
        model_step();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({o_arf, o_prf, o_npc, o_misp, o_st, o_br, o_commit, o_dis, o_head, o_tail} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: arf=%0d prf=%0d npc=%0d misp=%b st=%b br=%b commit=%b dis=%b head=%0d tail=%0d, want all 0",
                     o_arf, o_prf, o_npc, o_misp, o_st, o_br, o_commit, o_dis, o_head, o_tail);
        end
    endtask

    task automatic test_single_entry();
        apply_reset();
        id_valid = 1; id_arf = 0; id_prf = 0; id_st = 1; id_br = 1; cdb = 0;
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            total++;
            if (o_st !== 1'b1 || o_br !== 1'b1 || o_commit !== 1'b0 || o_head !== 5'd0 || o_tail !== 5'd1) begin
                bad++;
                $display("FAIL single_entry cycle %0d: st=%b br=%b commit=%b head=%0d tail=%0d, want 1 1 0 0 1",
                         c, o_st, o_br, o_commit, o_head, o_tail);
            end
            tick();
        end
    endtask

    task automatic test_fill_drain_squash();
        apply_reset();
        for (int i = 0; i < N; i++) begin
            id_valid = 1; id_arf = 5'(i); id_prf = 6'(i + 1); id_st = 0; id_br = 0;
            tick();
            total++;
            if (o_tail !== 5'(i + 1)) begin
                bad++;
                $display("FAIL fill_tail %0d: got %0d want %0d", i, o_tail, 5'(i + 1));
            end
        end
        idle_inputs();
        id_valid = 1; id_arf = 5'd9; id_prf = 6'd40;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (o_dis !== 1'b1 || o_tail !== 5'd0 || o_commit !== 1'b0) begin
                bad++;
                $display("FAIL full_stall cycle %0d: dis=%b tail=%0d commit=%b, want 1 0 0", c, o_dis, o_tail, o_commit);
            end
            tick();
        end
        idle_inputs();
        cdb = 6'd1;
        tick();
        total++;
        if (o_commit !== 1'b1 || o_dis !== 1'b0) begin
            bad++;
            $display("FAIL full_commit: commit=%b dis=%b, want 1 0", o_commit, o_dis);
        end
        cdb = 6'd0; id_valid = 1; id_arf = 5'd5; id_prf = 6'd33; id_br = 1;
        tick();
        idle_inputs();
        total++;
        if (o_head !== 5'd1 || o_tail !== 5'd1 || o_dis !== 1'b1) begin
            bad++;
            $display("FAIL commit_dispatch_same_slot: head=%0d tail=%0d dis=%b, want 1 1 1", o_head, o_tail, o_dis);
        end
        for (int k = 1; k < N; k++) begin
            cdb = 6'(k + 1);
            tick();
            total++;
            if (o_commit !== 1'b1 || o_head !== 5'(k)) begin
                bad++;
                $display("FAIL drain %0d: commit=%b head=%0d, want 1 %0d", k, o_commit, o_head, k);
            end
        end
        cdb = 6'd0; ex_br = 1; ex_num = 5'd0; ex_npc = 64'd200; ex_misp = 1;
        tick();
        idle_inputs();
        total++;
        if (o_arf !== 5'd5 || o_prf !== 6'd33 || o_npc !== 64'd200 || o_misp !== 1'b1 || o_commit !== 1'b1) begin
            bad++;
            $display("FAIL mispredict_head: arf=%0d prf=%0d npc=%0d misp=%b commit=%b, want 5 33 200 1 1",
                     o_arf, o_prf, o_npc, o_misp, o_commit);
        end
        tick();
        total++;
        if ({o_arf, o_prf, o_npc, o_misp, o_st, o_br, o_commit, o_dis, o_head, o_tail} !== '0) begin
            bad++;
            $display("FAIL squash_clears: arf=%0d prf=%0d npc=%0d misp=%b br=%b commit=%b head=%0d tail=%0d, want all 0",
                     o_arf, o_prf, o_npc, o_misp, o_br, o_commit, o_head, o_tail);
        end
    endtask

    task automatic test_store_stream();
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            id_valid = 1; id_arf = 5'd1; id_prf = 6'(i); id_st = 1;
            ex_br = 1; ex_num = 5'd0; ex_npc = 64'd77; ex_misp = 1;
            tick();
            total++;
            if (o_commit !== 1'b0 || o_npc !== 64'd0 || o_tail !== 5'(i + 1)) begin
                bad++;
                $display("FAIL store_ignores_branch %0d: commit=%b npc=%0d tail=%0d, want 0 0 %0d",
                         i, o_commit, o_npc, o_tail, i + 1);
            end
        end
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            ex_st = 1; ex_num = 5'(i);
            id_valid = 1; id_arf = 5'd2; id_prf = 6'(17 + i);
            tick();
            total++;
            if (o_commit !== 1'b1 || o_head !== 5'(i)) begin
                bad++;
                $display("FAIL store_commit %0d: commit=%b head=%0d, want 1 %0d", i, o_commit, o_head, i);
            end
        end
        idle_inputs();
        total++;
        if (o_tail !== 5'd0) begin
            bad++;
            $display("FAIL tail_wrap: got %0d want 0", o_tail);
        end
        for (int j = 0; j < 16; j++) begin
            cdb = 6'(17 + j);
            tick();
            total++;
            if (o_commit !== 1'b1 || o_head !== 5'(16 + j)) begin
                bad++;
                $display("FAIL cdb_drain %0d: commit=%b head=%0d, want 1 %0d", j, o_commit, o_head, 16 + j);
            end
        end
        idle_inputs();
        tick();
        total++;
        if (o_head !== 5'd0 || o_tail !== 5'd0 || o_commit !== 1'b0 || o_dis !== 1'b0
            || o_arf !== 5'd1 || o_st !== 1'b1) begin
            bad++;
            $display("FAIL empty_stale: head=%0d tail=%0d commit=%b dis=%b arf=%0d st=%b, want 0 0 0 0 1 1",
                     o_head, o_tail, o_commit, o_dis, o_arf, o_st);
        end
    endtask

    task automatic test_random();
        int unsigned s;
        int unsigned r;
        logic [4:0]  e_tail;
        bit          e_commit, e_dis;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_commit = (m_cnt != 0) && m_cmp[m_head];
            e_dis    = (m_cnt == N) && !e_commit;
            e_tail   = 5'((m_head + m_cnt) % N);
            total++;
            if (o_head !== 5'(m_head) || o_tail !== e_tail || o_commit !== e_commit || o_dis !== e_dis) begin
                bad++;
                $display("FAIL rand_ctrl cyc %0d: head=%0d tail=%0d commit=%b dis=%b, want %0d %0d %b %b",
                         cyc, o_head, o_tail, o_commit, o_dis, m_head, e_tail, e_commit, e_dis);
            end
            total++;
            if (o_arf !== m_arf[m_head] || o_prf !== m_prf[m_head] || o_npc !== m_npc[m_head]
                || o_misp !== m_misp[m_head] || o_st !== m_st[m_head] || o_br !== m_br[m_head]) begin
                bad++;
                $display("FAIL rand_head cyc %0d: arf=%0d prf=%0d npc=%0d misp=%b st=%b br=%b, want %0d %0d %0d %b %b %b",
                         cyc, o_arf, o_prf, o_npc, o_misp, o_st, o_br, m_arf[m_head], m_prf[m_head],
                         m_npc[m_head], m_misp[m_head], m_st[m_head], m_br[m_head]);
            end
            idle_inputs();
            id_valid = ($urandom_range(0, 3) != 0);
            id_arf   = 5'($urandom);
            id_prf   = 6'($urandom);
            r        = $urandom_range(0, 9);
            id_st    = (r == 6 || r == 7 || r == 9);
            id_br    = (r >= 8);
            if (m_cnt != 0 && $urandom_range(0, 9) < 7) begin
                s   = (m_head + $urandom_range(0, m_cnt - 1)) % N;
                cdb = m_prf[s];
            end else begin
                cdb = 6'($urandom);
            end
            if (m_cnt != 0 && $urandom_range(0, 9) < 8)
                ex_num = 5'((m_head + $urandom_range(0, m_cnt - 1)) % N);
            else
                ex_num = 5'($urandom);
            ex_st   = ($urandom_range(0, 9) < 4);
            ex_br   = ($urandom_range(0, 9) < 4);
            ex_npc  = {32'($urandom), 32'($urandom)};
            ex_misp = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #12;
        test_reset();
        test_single_entry();
        test_fill_drain_squash();
        test_store_stream();
        test_fill_drain_squash();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
